mem_bus_arbiter: RTL and testbench

Two-requester arbiter sharing a single downstream `memory_bus` between the CPU core (port 0) and a DMA/graphics requester (port 1). Each upstream port speaks the same single-cycle-dispatch / busy protocol as the downstream bus, so either requester connects to it as if it owned memory. One transaction is in flight downstream at a time. Read data is returned only to the port that issued the request.

---
 rtl/mem_bus_arbiter_pkg.sv | 27 ++
 rtl/mem_bus_arbiter_if.sv | 26 ++
 rtl/mem_bus_arbiter_req_latch.sv | 85 ++++++++
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - package mem: bus width enum plus arbiter state/op types
package mem;

  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_width_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // A lone pending port always wins; prefer1 only breaks a tie.
  function automatic logic pick_port(input logic pend0, input logic pend1, input logic prefer1);
    return (pend0 && pend1) ? prefer1 : pend1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// rtl/mem_bus_arbiter_if.sv - memory_bus interface: single-cycle dispatch with busy handshake
interface memory_bus #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import mem::*;

  logic [ADDR_W-1:0] addr;
  mem_width_t        mem_width;
  logic [DATA_W-1:0] write_data;
  logic              dispatch_read;
  logic              dispatch_write;
  logic              busy;
  logic [DATA_W-1:0] read_data;

  modport master (
    output addr, mem_width, write_data, dispatch_read, dispatch_write,
    input  busy, read_data
  );

  modport slave (
    input  addr, mem_width, write_data, dispatch_read, dispatch_write,
    output busy, read_data
  );

endinterface

// File: rtl/mem_bus_arbiter_req_latch.sv
// rtl/mem_bus_arbiter_req_latch.sv - per-port request holder: pending/op/fields, busy and
// read-data return, protocol error detection
module mem_arb_req_latch
  import mem::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  memory_bus.slave          up,
  input  logic              complete,
  input  logic [DATA_W-1:0] rdata,
  output logic              pending,
  output arb_op_t           op,
  output logic [ADDR_W-1:0] addr,
  output mem_width_t        width,
  output logic [DATA_W-1:0] wdata,
  output logic              err
);

  logic              pending_q, pending_d;
  arb_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_width_t        width_q, width_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              dispatch;

  assign dispatch = up.dispatch_read | up.dispatch_write;

  always_comb begin
    pending_d = pending_q;
    op_d      = op_q;
    addr_d    = addr_q;
    width_d   = width_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err       = 1'b0;
    if (complete) begin
      pending_d = 1'b0;
      if (op_q == OP_READ) rdata_d = rdata;
    end
    // complete only fires while pending_q is set, so a dispatch here is an error
    if (dispatch) begin
      if (pending_q) begin
        err = 1'b1;
      end else begin
        pending_d = 1'b1;
        op_d      = up.dispatch_write ? OP_WRITE : OP_READ;
        addr_d    = up.addr;
        width_d   = up.mem_width;
        wdata_d   = up.write_data;
        err       = up.dispatch_read & up.dispatch_write;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending_q <= 1'b0;
      op_q      <= OP_READ;
      addr_q    <= '0;
      width_q   <= DWORD;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      pending_q <= pending_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      width_q   <= width_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

  assign up.busy      = pending_q;
  assign up.read_data = rdata_q;
  assign pending      = pending_q;
  assign op           = op_q;
  assign addr         = addr_q;
  assign width        = width_q;
  assign wdata        = wdata_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port arbiter onto one memory_bus; MEM_ARB_ROUND_ROBIN_EN
// selects round-robin tie-break instead of fixed port-0 priority
module mem_bus_arbiter
  import mem::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic      clk_in,
  input  logic      rst_in,
  memory_bus.slave  up0,
  memory_bus.slave  up1,
  memory_bus.master down,
  output logic      proto_err
);

  logic [1:0]        pending;
  logic [1:0]        complete;
  logic [1:0]        req_err;
  arb_op_t           req_op    [2];
  logic [ADDR_W-1:0] req_addr  [2];
  mem_width_t        req_width [2];
  logic [DATA_W-1:0] req_wdata [2];
  logic              winner;

  arb_state_t        state_q, state_d;
  logic              grant_q, grant_d;
  logic              disp_rd_q, disp_rd_d;
  logic              disp_wr_q, disp_wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  mem_width_t        width_q, width_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              proto_err_q, proto_err_d;

  mem_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req0 (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .up       (up0),
    .complete (complete[0]),
    .rdata    (down.read_data),
    .pending  (pending[0]),
    .op       (req_op[0]),
    .addr     (req_addr[0]),
    .width    (req_width[0]),
    .wdata    (req_wdata[0]),
    .err      (req_err[0])
  );

  mem_arb_req_latch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req1 (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .up       (up1),
    .complete (complete[1]),
    .rdata    (down.read_data),
    .pending  (pending[1]),
    .op       (req_op[1]),
    .addr     (req_addr[1]),
    .width    (req_width[1]),
    .wdata    (req_wdata[1]),
    .err      (req_err[1])
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    last_grant_d = last_grant_q;
    if (state_q == IDLE && |pending) last_grant_d = winner;
  end

  // Reset to port 1 so the first tie goes to port 0.
  always_ff @(posedge clk_in) begin
    if (rst_in) last_grant_q <= 1'b1;
    else        last_grant_q <= last_grant_d;
  end

  assign winner = pick_port(pending[0], pending[1], ~last_grant_q);
`else
  assign winner = pick_port(pending[0], pending[1], 1'b0);
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|pending) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (!down.busy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d     = grant_q;
    disp_rd_d   = 1'b0;
    disp_wr_d   = 1'b0;
    addr_d      = addr_q;
    width_d     = width_q;
    wdata_d     = wdata_q;
    complete    = 2'b00;
    proto_err_d = proto_err_q | (|req_err);
    case (state_q)
      IDLE: begin
        if (|pending) begin
          grant_d   = winner;
          addr_d    = req_addr[winner];
          width_d   = req_width[winner];
          wdata_d   = req_wdata[winner];
          disp_wr_d = (req_op[winner] == OP_WRITE);
          disp_rd_d = (req_op[winner] == OP_READ);
        end
      end
      WAIT: begin
        if (!down.busy) complete[grant_q] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      grant_q     <= 1'b0;
      disp_rd_q   <= 1'b0;
      disp_wr_q   <= 1'b0;
      addr_q      <= '0;
      width_q     <= DWORD;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      disp_rd_q   <= disp_rd_d;
      disp_wr_q   <= disp_wr_d;
      addr_q      <= addr_d;
      width_q     <= width_d;
      wdata_q     <= wdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign down.addr           = addr_q;
  assign down.mem_width      = width_q;
  assign down.write_data     = wdata_q;
  assign down.dispatch_read  = disp_rd_q;
  assign down.dispatch_write = disp_wr_q;
  assign proto_err           = proto_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and random stimulus against a transaction-level arbiter model
module tb_mem_bus_arbiter;
  import mem::*;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_err;

  always #5 clk = ~clk;

  memory_bus #(.ADDR_W(AW), .DATA_W(DW)) bus_up0 ();
  memory_bus #(.ADDR_W(AW), .DATA_W(DW)) bus_up1 ();
  memory_bus #(.ADDR_W(AW), .DATA_W(DW)) bus_down ();

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_in    (clk),
    .rst_in    (rst),
    .up0       (bus_up0),
    .up1       (bus_up1),
    .down      (bus_down),
    .proto_err (proto_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h1234_5678;
  endfunction

  // Number of cycles the memory holds busy for a transaction at address a.
  function automatic int busy_len(input logic [31:0] a);
    return (a[1:0] == 2'd3) ? 1 : 2 + int'(a[1:0]);
  endfunction

  // Memory: busy from the cycle after dispatch for busy_len cycles, data valid when busy drops.
  int          mem_left;
  logic        mem_pend;
  logic [31:0] mem_pend_addr, mem_cur_addr;
  initial begin
    mem_left = 0;
    mem_pend = 1'b0;
    mem_pend_addr = '0;
    mem_cur_addr = '0;
    bus_down.busy = 1'b0;
    bus_down.read_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        mem_left = 0;
        mem_pend = 1'b0;
        bus_down.busy = 1'b0;
      end else begin
        if (mem_pend) begin
          mem_left = busy_len(mem_pend_addr);
          mem_cur_addr = mem_pend_addr;
        end
        if (mem_left > 0) begin
          bus_down.busy = 1'b1;
          bus_down.read_data = $urandom;
          mem_left--;
        end else if (bus_down.busy) begin
          bus_down.busy = 1'b0;
          bus_down.read_data = mem_data(mem_cur_addr);
        end
        mem_pend = bus_down.dispatch_read | bus_down.dispatch_write;
        mem_pend_addr = bus_down.addr;
      end
    end
  end

  // Transaction-level reference model.
  logic        m_out   [2];
  logic        m_gnt   [2];
  int          m_done  [2];
  arb_op_t     m_op    [2];
  logic [31:0] m_addr  [2];
  mem_width_t  m_width [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rd    [2];
  logic        m_err;
  int          m_idle_from, m_last, m_disp_cyc, m_disp_port;
  logic [31:0] m_daddr, m_dwdata;
  mem_width_t  m_dwidth;

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      m_out[p] = 1'b0; m_gnt[p] = 1'b0; m_done[p] = 0; m_rd[p] = '0;
    end
    m_err = 1'b0; m_idle_from = 0; m_last = 1; m_disp_cyc = -1; m_disp_port = 0;
    m_daddr = '0; m_dwdata = '0; m_dwidth = DWORD;
  endtask

  logic        s_rd [2], s_wr [2];
  logic [31:0] s_addr [2], s_wdata [2];
  mem_width_t  s_width [2];

  task automatic model_accept(input int p);
    if (m_out[p]) begin
      m_err = 1'b1;
    end else begin
      m_out[p] = 1'b1; m_gnt[p] = 1'b0;
      m_op[p] = s_wr[p] ? OP_WRITE : OP_READ;
      m_addr[p] = s_addr[p]; m_width[p] = s_width[p]; m_wdata[p] = s_wdata[p];
      if (s_rd[p] && s_wr[p]) m_err = 1'b1;
    end
  endtask

  task automatic model_advance();
    logic e0, e1;
    int w;
    for (int p = 0; p < 2; p++)
      if (m_out[p] && m_gnt[p] && m_done[p] == cyc) begin
        m_out[p] = 1'b0; m_gnt[p] = 1'b0;
        if (m_op[p] == OP_READ) m_rd[p] = mem_data(m_addr[p]);
      end
    e0 = m_out[0] && !m_gnt[0];
    e1 = m_out[1] && !m_gnt[1];
    if (cyc >= m_idle_from && (e0 || e1)) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w = (e0 && e1) ? (m_last == 0 ? 1 : 0) : (e1 ? 1 : 0);
`else
      w = e0 ? 0 : 1;
`endif
      m_last = w; m_gnt[w] = 1'b1;
      m_disp_cyc = cyc + 1; m_disp_port = w;
      m_done[w] = cyc + 3 + busy_len(m_addr[w]);
      m_idle_from = m_done[w];
    end
    if (m_disp_cyc == cyc) begin
      m_daddr = m_addr[m_disp_port]; m_dwidth = m_width[m_disp_port]; m_dwdata = m_wdata[m_disp_port];
    end
  endtask

  int          obs_dr_cnt, obs_dw_cnt, obs_busy0_cnt, fall0_cyc;
  logic        prev_busy0;
  logic [31:0] obs_addr_q [$];
  mem_width_t  obs_dwidth;
  logic [31:0] obs_dwdata;

  task automatic clear_obs();
    obs_dr_cnt = 0; obs_dw_cnt = 0; obs_busy0_cnt = 0; fall0_cyc = -1;
    obs_addr_q.delete();
  endtask

  task automatic check_outputs();
    logic exp_rd, exp_wr;
    exp_rd = (m_disp_cyc == cyc) && (m_op[m_disp_port] == OP_READ);
    exp_wr = (m_disp_cyc == cyc) && (m_op[m_disp_port] == OP_WRITE);
    chk("dispatch_read", 64'(bus_down.dispatch_read), 64'(exp_rd));
    chk("dispatch_write", 64'(bus_down.dispatch_write), 64'(exp_wr));
    chk("down_addr", 64'(bus_down.addr), 64'(m_daddr));
    chk("down_width", 64'(bus_down.mem_width), 64'(m_dwidth));
    chk("down_wdata", 64'(bus_down.write_data), 64'(m_dwdata));
    chk("up0_busy", 64'(bus_up0.busy), 64'(m_out[0]));
    chk("up1_busy", 64'(bus_up1.busy), 64'(m_out[1]));
    chk("up0_rdata", 64'(bus_up0.read_data), 64'(m_rd[0]));
    chk("up1_rdata", 64'(bus_up1.read_data), 64'(m_rd[1]));
    chk("proto_err", 64'(proto_err), 64'(m_err));
    if (bus_down.dispatch_read) begin obs_dr_cnt++; obs_addr_q.push_back(bus_down.addr); end
    if (bus_down.dispatch_write) begin
      obs_dw_cnt++; obs_addr_q.push_back(bus_down.addr);
      obs_dwidth = bus_down.mem_width; obs_dwdata = bus_down.write_data;
    end
    if (bus_up0.busy) obs_busy0_cnt++;
    if (prev_busy0 && !bus_up0.busy) fall0_cyc = cyc;
    prev_busy0 = bus_up0.busy;
  endtask

  task automatic drive_port(input int p);
    logic        rd, wr;
    logic [31:0] a, d;
    mem_width_t  w;
    rd = s_rd[p]; wr = s_wr[p];
    a = (rd || wr) ? s_addr[p] : $urandom;
    d = (rd || wr) ? s_wdata[p] : $urandom;
    w = (rd || wr) ? s_width[p] : mem_width_t'($urandom_range(0, 3));
    if (p == 0) begin
      bus_up0.dispatch_read = rd; bus_up0.dispatch_write = wr;
      bus_up0.addr = a; bus_up0.write_data = d; bus_up0.mem_width = w;
    end else begin
      bus_up1.dispatch_read = rd; bus_up1.dispatch_write = wr;
      bus_up1.addr = a; bus_up1.write_data = d; bus_up1.mem_width = w;
    end
  endtask

  task automatic tick();
    logic was_rst;
    drive_port(0);
    drive_port(1);
    was_rst = rst;
    if (!rst)
      for (int p = 0; p < 2; p++) if (s_rd[p] || s_wr[p]) model_accept(p);
    @(posedge clk);
    #3;
    cyc++;
    if (was_rst) model_reset();
    else model_advance();
    check_outputs();
    for (int p = 0; p < 2; p++) begin s_rd[p] = 1'b0; s_wr[p] = 1'b0; end
  endtask

  task automatic req(input int p, input logic wr, input logic rd, input logic [31:0] a,
                     input mem_width_t w, input logic [31:0] d);
    s_rd[p] = rd; s_wr[p] = wr; s_addr[p] = a; s_width[p] = w; s_wdata[p] = d;
  endtask

  task automatic wait_quiet(input int max_cyc);
    for (int i = 0; i < max_cyc && (m_out[0] || m_out[1]); i++) tick();
    chk("quiet_timeout", 64'(m_out[0] | m_out[1]), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int t_req;

  initial begin
    for (int p = 0; p < 2; p++) begin s_rd[p] = 1'b0; s_wr[p] = 1'b0; end
    prev_busy0 = 1'b0;
    obs_dwidth = DWORD; obs_dwdata = '0;
    model_reset();
    clear_obs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_up0_busy", 64'(bus_up0.busy), 64'(0));
    chk("rst_down_width", 64'(bus_down.mem_width), 64'(DWORD));

    // single read, port 0
    clear_obs();
    t_req = cyc;
    req(0, 1'b0, 1'b1, 32'h100, DWORD, 32'h0);
    tick();
    wait_quiet(40);
    chk("t1_disp_cnt", 64'(obs_dr_cnt), 64'(1));
    chk("t1_addr", 64'(obs_addr_q.size() > 0 ? obs_addr_q[0] : 32'hFFFF_FFFF), 64'(32'h100));
    chk("t1_rdata", 64'(bus_up0.read_data), 64'(32'hDEADBEEF));
    chk("t1_latency", 64'(fall0_cyc - t_req), 64'(6));

    // byte write, port 1
    clear_obs();
    req(1, 1'b1, 1'b0, 32'h2000, BYTE, 32'h55);
    tick();
    wait_quiet(40);
    chk("t2_dw_cnt", 64'(obs_dw_cnt), 64'(1));
    chk("t2_width", 64'(obs_dwidth), 64'(BYTE));
    chk("t2_wdata", 64'(obs_dwdata), 64'(32'h55));
    chk("t2_up1_rdata", 64'(bus_up1.read_data), 64'(0));
    chk("t2_up0_busy_cycles", 64'(obs_busy0_cnt), 64'(0));

    // simultaneous reads, three rounds
    clear_obs();
    for (int r = 0; r < 3; r++) begin
      req(0, 1'b0, 1'b1, 32'h1000 + 32'(r * 16), WORD, 32'h0);
      req(1, 1'b0, 1'b1, 32'h3001 + 32'(r * 16), HALF, 32'h0);
      tick();
      wait_quiet(60);
    end
    for (int k = 0; k < 6; k++)
      chk("t3_order", 64'(obs_addr_q.size() > k ? obs_addr_q[k] : 32'hFFFF_FFFF),
          64'(((k % 2) == 0 ? 32'h1000 : 32'h3001) + 32'((k / 2) * 16)));
    chk("t3_up1_own_data", 64'(bus_up1.read_data), 64'(mem_data(32'h3021)));
    chk("t3_up0_own_data", 64'(bus_up0.read_data), 64'(mem_data(32'h1020)));

    // dispatch while busy
    clear_obs();
    req(0, 1'b0, 1'b1, 32'h500, WORD, 32'h0);
    tick();
    req(0, 1'b0, 1'b1, 32'h600, WORD, 32'h0);
    tick();
    wait_quiet(40);
    repeat (3) tick();
    chk("t5_disp_cnt", 64'(obs_dr_cnt + obs_dw_cnt), 64'(1));
    chk("t5_proto_err_sticky", 64'(proto_err), 64'(1));

    // read and write together
    do_reset();
    chk("t7_err_cleared", 64'(proto_err), 64'(0));
    clear_obs();
    req(0, 1'b1, 1'b1, 32'h700, WORD, 32'h77);
    tick();
    wait_quiet(40);
    chk("t7_dw_cnt", 64'(obs_dw_cnt), 64'(1));
    chk("t7_dr_cnt", 64'(obs_dr_cnt), 64'(0));
    chk("t7_proto_err", 64'(proto_err), 64'(1));

    // reset during WAIT, then a port 1 read
    do_reset();
    req(0, 1'b0, 1'b1, 32'h802, WORD, 32'h0);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("t6_disp_rd", 64'(bus_down.dispatch_read), 64'(0));
    chk("t6_addr", 64'(bus_down.addr), 64'(0));
    chk("t6_width", 64'(bus_down.mem_width), 64'(DWORD));
    chk("t6_busy0", 64'(bus_up0.busy), 64'(0));
    chk("t6_rdata0", 64'(bus_up0.read_data), 64'(0));
    rst = 1'b0;
    req(1, 1'b0, 1'b1, 32'h900, DWORD, 32'h0);
    tick();
    wait_quiet(40);
    chk("t6_up1_rdata", 64'(bus_up1.read_data), 64'(mem_data(32'h900)));

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        for (int p = 0; p < 2; p++)
          if ($urandom_range(0, 2) == 0 && (!m_out[p] || $urandom_range(0, 29) == 0)) begin
            if ($urandom_range(0, 39) == 0)
              req(p, 1'b1, 1'b1, $urandom, mem_width_t'($urandom_range(0, 3)), $urandom);
            else begin
              logic wr;
              wr = 1'($urandom_range(0, 1));
              req(p, wr, ~wr, $urandom, mem_width_t'($urandom_range(0, 3)), $urandom);
            end
          end
        tick();
      end
    end
    wait_quiet(40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
